// File: rtl/my_seg7_mux_if.sv
// rtl/my_seg7_mux_if.sv - value/display signal bundle for the multiplexed 7-segment driver
// Purpose: groups the application-side controls and the display-pin outputs
// of my_seg7_mux so they travel as one port.
// Signals:
//   en          app -> driver  display enable (low acts as reset)
//   num         app -> driver  4*DIGITS hex nibbles, digit 0 least significant
//   dp          app -> driver  per-digit decimal point, active high
//   lzs         app -> driver  leading-zero suppression enable
//   brightness  app -> driver  lit sub-ticks per digit slot
//   tick_div    app -> driver  clocks per sub-tick (0 and 1 both mean every clock)
//   seg         driver -> pins segments {a,b,c,d,e,f,g}, active high
//   seg_dp      driver -> pins decimal-point segment, active high
//   seg_gnd     driver -> pins digit select, active low
//   frame       driver -> app  one-clock pulse at each frame start
interface my_seg7_mux_if #(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 16,
  parameter int BRT_W  = 4
);
  logic                en;
  logic [4*DIGITS-1:0] num;
  logic [DIGITS-1:0]   dp;
  logic                lzs;
  logic [BRT_W-1:0]    brightness;
  logic [DIV_W-1:0]    tick_div;
  logic [6:0]          seg;
  logic                seg_dp;
  logic [DIGITS-1:0]   seg_gnd;
  logic                frame;

  modport master (
    output en, num, dp, lzs, brightness, tick_div,
    input  seg, seg_dp, seg_gnd, frame
  );

  modport slave (
    input  en, num, dp, lzs, brightness, tick_div,
    output seg, seg_dp, seg_gnd, frame
  );
endinterface

// File: rtl/my_seg7_mux.sv
// rtl/my_seg7_mux.sv - N-digit multiplexed common-cathode 7-segment display driver
// Purpose: scans DIGITS digits over one shared segment bus with a programmable
// scan prescaler, PWM brightness, per-digit decimal points, optional
// leading-zero suppression and frame-coherent snapshots of the inputs.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  my_seg7_mux_if.slave: en/num/dp/lzs/brightness/tick_div in,
//        seg/seg_dp/seg_gnd/frame out (all outputs registered)
module my_seg7_mux #(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 16,
  parameter int BRT_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  my_seg7_mux_if.slave bus
);

  localparam int               DI_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DI_W-1:0]  DI_LAST = DI_W'(DIGITS - 1);
  localparam logic [BRT_W-1:0] SC_LAST = '1;

  // ST_START is the single frame-start cycle after reset/enable: the
  // snapshot is taken while the scan counters hold at zero, so the first
  // slot of digit 0 already uses the freshly captured value.
  typedef enum logic {ST_START, ST_SCAN} state_t;

  state_t state_q, state_d;

  logic                clear;
  logic [DIV_W-1:0]    pc_q, pc_d;
  logic [BRT_W-1:0]    sc_q, sc_d;
  logic [DI_W-1:0]     di_q, di_d;
  logic                tick;
  logic                frame_start;

  logic [4*DIGITS-1:0] num_q;
  logic [DIGITS-1:0]   dp_q;
  logic                lzs_q;

  logic [DIGITS-1:0]   lead_zero;
  logic                run;
  logic [3:0]          nib;
  logic                lit;
  logic                blank;

  logic [6:0]          seg_d, seg_q;
  logic                seg_dp_d, seg_dp_q;
  logic [DIGITS-1:0]   seg_gnd_d, seg_gnd_q;
  logic                frame_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  assign clear = rst | ~bus.en;

  // The >= compare lets a live decrease of tick_div pull pc back on the
  // very next cycle instead of counting all the way round the register.
  assign tick = (bus.tick_div <= DIV_W'(1)) ||
                (pc_q >= (bus.tick_div - DIV_W'(1)));

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    pc_d        = pc_q;
    sc_d        = sc_q;
    di_d        = di_q;
    case (state_q)
      ST_START: begin
        frame_start = 1'b1;
        state_d     = ST_SCAN;
      end
      ST_SCAN: begin
        if (tick) begin
          pc_d = '0;
          sc_d = sc_q + 1'b1;
          if (sc_q == SC_LAST) begin
            if (di_q == DI_LAST) begin
              di_d        = '0;
              frame_start = 1'b1;
            end else begin
              di_d = di_q + 1'b1;
            end
          end
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  // lead_zero[i] is set when digit i and every digit above it are zero with
  // no decimal point, i.e. digit i is still inside the leading-zero run.
  always_comb begin
    lead_zero = '0;
    run       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run          = run & (num_q[4*i +: 4] == 4'd0) & ~dp_q[i];
      lead_zero[i] = run;
    end
  end

  assign nib   = num_q[{di_q, 2'b00} +: 4];
  assign lit   = (sc_q < bus.brightness);
  assign blank = lzs_q && (di_q != '0) && lead_zero[di_q];

  // A blanked digit still pulls its select low so every slot loads the
  // supply the same way; only the segments are suppressed.
  always_comb begin
    seg_d     = '0;
    seg_dp_d  = 1'b0;
    seg_gnd_d = '1;
    if ((state_q == ST_SCAN) && lit) begin
      seg_gnd_d = ~(DIGITS'(1) << di_q);
      if (!blank) begin
        seg_d    = hex7(nib);
        seg_dp_d = dp_q[di_q];
      end
    end
  end

  // Select and segments come from the same registered (di, sc) state, so a
  // digit change never shows the new select with the old segments.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= ST_START;
      pc_q      <= '0;
      sc_q      <= '0;
      di_q      <= '0;
      num_q     <= '0;
      dp_q      <= '0;
      lzs_q     <= 1'b0;
      seg_q     <= '0;
      seg_dp_q  <= 1'b0;
      seg_gnd_q <= '1;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sc_q      <= sc_d;
      di_q      <= di_d;
      if (frame_start) begin
        num_q <= bus.num;
        dp_q  <= bus.dp;
        lzs_q <= bus.lzs;
      end
      seg_q     <= seg_d;
      seg_dp_q  <= seg_dp_d;
      seg_gnd_q <= seg_gnd_d;
      frame_q   <= frame_start;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.seg_dp  = seg_dp_q;
  assign bus.seg_gnd = seg_gnd_q;
  assign bus.frame   = frame_q;

endmodule
